noc_rx_merge: RTL and testbench

Clocked receive-side merge stage downstream of the 1-to-16 address split. It collects 8-bit packets `{data[3:0], addr[3:0]}` from the 16 split output ports and arbitrates them round-robin into a DEPTH-entry FIFO. It presents one ordered stream to the local core interface, tagged with the originating port. It also checks that each packet's addr field matches the port it arrived on, and counts delivered packets.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/rr_arbiter16.sv | 45 ++++
 rtl/noc_rx_merge.sv | 99 +++++++++
 tb/tb_noc_rx_merge.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet layout and fixed widths used by the split,
// the traffic generator and the receive-side merge.
package noc_pkg;

   localparam int WIDTH  = 8;
   localparam int ADDR_W = 4;
   localparam int NPORTS = 16;

   typedef struct packed {
      logic [3:0] data;
      logic [3:0] addr;
   } packet_t;

   // One FIFO slot: the packet plus the port it arrived on.
   typedef struct packed {
      logic [ADDR_W-1:0] port;
      packet_t           pkt;
   } fifo_entry_t;

   function automatic logic [ADDR_W-1:0] next_port(input logic [ADDR_W-1:0] p);
      return p + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter: grants the first requester at or after ptr,
// then moves ptr just past the winner.
module rr_arbiter16 import noc_pkg::*; (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       req,
   input  logic              enable,
   output logic [15:0]       gnt,
   output logic [ADDR_W-1:0] gnt_idx
);

   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] idx;
   logic              found;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment; otherwise synthesis infers a latch to hold it.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = ptr;
      if (enable) begin
         for (int k = 0; k < 16; k++) begin
            idx = ptr + ADDR_W'(k);
            if (!found && req[idx]) begin
               found        = 1'b1;
               gnt[idx]     = 1'b1;
               gnt_idx      = idx;
            end
         end
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= next_port(gnt_idx);
      end
   end

endmodule

// File: rtl/noc_rx_merge.sv
// Receive-side merge: round-robin collects packets from the 16 split ports into
// a small FIFO, tags each with its source port and checks its addr field.
module noc_rx_merge import noc_pkg::*; #(
   parameter int WIDTH  = noc_pkg::WIDTH,
   parameter int NPORTS = noc_pkg::NPORTS,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NPORTS-1:0]       in_valid,
   output logic [NPORTS-1:0]       in_ready,
   input  logic [NPORTS*WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [ADDR_W-1:0]       out_port,
   output logic                    mismatch_err,
   output logic [15:0]             pkt_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fifo_entry_t       mem [DEPTH];
   fifo_entry_t       head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              push;
   logic              pop;
   logic [15:0]       gnt;
   logic [ADDR_W-1:0] gnt_idx;
   packet_t           in_pkt;

   // Full uses the registered count, so a same-cycle pop never frees a slot
   // early and out_ready has no path to in_ready.
   assign full = (count == CNT_W'(DEPTH));

   rr_arbiter16 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (in_valid),
      .enable  (!reset && !full),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign in_ready = gnt;
   assign push     = |gnt;
   assign in_pkt   = packet_t'(in_data[int'(gnt_idx)*WIDTH +: WIDTH]);

   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign head      = mem[rd_ptr];
   assign out_data  = head.pkt;
   assign out_port  = head.port;

   // NOTE: the storage array has no reset; stale slots are never visible
   // because out_valid follows count, which is reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{port: gnt_idx, pkt: in_pkt};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mismatch_err <= 1'b0;
      end else if (push && (in_pkt.addr != gnt_idx)) begin
         mismatch_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count <= '0;
      end else if (pop && (pkt_count != 16'hFFFF)) begin
         pkt_count <= pkt_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_noc_rx_merge.sv
// Self-checking bench for noc_rx_merge: a reference arbiter/FIFO model feeds a
// scoreboard every cycle, plus directed checks for each scenario.
module tb_noc_rx_merge;
   import noc_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [3:0] port;
      logic [7:0] data;
   } sb_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [15:0]  in_valid;
   logic [15:0]  in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic [3:0]   out_port;
   logic         mismatch_err;
   logic [15:0]  pkt_count;

   int n_checks = 0;
   int n_pass   = 0;

   sb_t        sb[$];
   logic [7:0] delivered[$];
   logic [3:0] m_ptr;
   logic [15:0] m_pkt;
   logic       m_mis;
   bit         armed = 1'b0;

   always #5 clk = ~clk;

   noc_rx_merge #(.WIDTH(8), .NPORTS(16), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_port     (out_port),
      .mismatch_err (mismatch_err),
      .pkt_count    (pkt_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pkt(input int p, input logic [7:0] v);
      in_data[p*8 +: 8] = v;
   endtask

   // Reference model, sampled mid-cycle while inputs and outputs are stable;
   // its next state is what the DUT should hold after the coming edge.
   always @(negedge clk) begin
      int g;
      logic [15:0] exp_rdy;
      g = -1;
      exp_rdy = '0;
      if (armed) begin
         if (!reset && sb.size() < DEPTH) begin
            for (int k = 0; k < 16; k++) begin
               int p;
               p = (int'(m_ptr) + k) % 16;
               if (g < 0 && in_valid[p]) g = p;
            end
         end
         if (g >= 0) exp_rdy[g] = 1'b1;
         check("in_ready", in_ready, exp_rdy);
         check("out_valid", out_valid, sb.size() != 0);
         check("pkt_count", pkt_count, m_pkt);
         check("mismatch_err", mismatch_err, m_mis);
         if (sb.size() != 0 && out_valid) begin
            check("out_data", out_data, sb[0].data);
            check("out_port", out_port, sb[0].port);
         end
      end
      if (reset) begin
         sb.delete();
         m_ptr = '0;
         m_pkt = '0;
         m_mis = 1'b0;
         armed = 1'b1;
      end else if (armed) begin
         if (sb.size() != 0 && out_ready) begin
            if (out_valid) delivered.push_back(out_data);
            void'(sb.pop_front());
            if (m_pkt != 16'hFFFF) m_pkt++;
         end
         if (g >= 0) begin
            sb_t e;
            e.port = 4'(g);
            e.data = in_data[g*8 +: 8];
            sb.push_back(e);
            m_ptr = 4'((g + 1) % 16);
            if (e.data[3:0] != 4'(g)) m_mis = 1'b1;
         end
      end
   end

   initial begin
      logic [7:0] exp_full[5];
      exp_full = '{8'h13, 8'h23, 8'h33, 8'h43, 8'h53};

      // Reset with every port requesting.
      reset     = 1'b1;
      out_ready = 1'b0;
      in_valid  = 16'hFFFF;
      for (int i = 0; i < 16; i++) set_pkt(i, {4'(i) ^ 4'hA, 4'(i)});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_in_ready", in_ready, 16'h0);
         check("rst_out_valid", out_valid, 1'b0);
         check("rst_pkt_count", pkt_count, 16'h0);
         check("rst_mismatch", mismatch_err, 1'b0);
         step();
      end
      reset    = 1'b0;
      in_valid = '0;

      // Single packet on port 5.
      step();
      set_pkt(5, 8'hA5);
      in_valid  = 16'h1 << 5;
      out_ready = 1'b1;
      @(negedge clk);
      check("sp_ready", in_ready[5], 1'b1);
      step();
      in_valid = '0;
      @(negedge clk);
      check("sp_valid", out_valid, 1'b1);
      check("sp_data", out_data, 8'hA5);
      check("sp_port", out_port, 4'd5);
      step();
      @(negedge clk);
      check("sp_count", pkt_count, 16'd1);
      check("sp_mismatch", mismatch_err, 1'b0);
      step();

      // Reset pulse so fairness starts from ptr=0.
      reset = 1'b1;
      step();
      reset    = 1'b0;
      in_valid = 16'hFFFF;
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         check("fair_gnt", in_ready, 16'h1 << (i % 16));
         if (i > 0) check("fair_port", out_port, (i - 1) % 16);
         step();
      end
      in_valid = '0;
      @(negedge clk);
      check("fair_port", out_port, 4'd1);
      step();
      @(negedge clk);
      check("fair_count", pkt_count, 16'd18);
      step();

      // Fill the FIFO from port 3 while the consumer stalls.
      delivered.delete();
      out_ready = 1'b0;
      begin
         int k;
         k = 0;
         set_pkt(3, exp_full[0]);
         in_valid = 16'h1 << 3;
         for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check(c < 4 ? "full_fill" : "full_block", in_ready[3], c < 4);
            step();
            if (c < 4) begin
               k++;
               set_pkt(3, exp_full[k]);
            end
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("full_pop_same", in_ready[3], 1'b0);
      check("full_head", out_data, 8'h13);
      step();
      @(negedge clk);
      check("full_accept5", in_ready[3], 1'b1);
      step();
      in_valid = '0;
      repeat (6) step();
      check("full_n", delivered.size(), 5);
      for (int j = 0; j < 5 && j < delivered.size(); j++)
         check("full_order", delivered[j], exp_full[j]);

      // Wrong addr field on port 7.
      set_pkt(7, 8'h32);
      in_valid = 16'h1 << 7;
      @(negedge clk);
      check("mm_ready", in_ready[7], 1'b1);
      step();
      in_valid = '0;
      @(negedge clk);
      check("mm_err", mismatch_err, 1'b1);
      check("mm_data", out_data, 8'h32);
      check("mm_port", out_port, 4'd7);
      repeat (3) step();
      @(negedge clk);
      check("mm_sticky", mismatch_err, 1'b1);
      step();

      // Reset with two packets queued.
      out_ready = 1'b0;
      set_pkt(9, 8'h69);
      set_pkt(2, 8'h52);
      in_valid = (16'h1 << 9) | (16'h1 << 2);
      @(negedge clk);
      check("mr_gnt9", in_ready, 16'h1 << 9);
      step();
      @(negedge clk);
      check("mr_gnt2", in_ready, 16'h1 << 2);
      step();
      in_valid = '0;
      @(negedge clk);
      check("mr_queued", out_valid, 1'b1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("mr_empty", out_valid, 1'b0);
      check("mr_mismatch", mismatch_err, 1'b0);
      step();
      set_pkt(0, 8'hE0);
      in_valid = 16'hFFFF;
      @(negedge clk);
      check("mr_prio", in_ready, 16'h0001);
      step();
      in_valid  = '0;
      out_ready = 1'b1;
      @(negedge clk);
      check("mr_data", out_data, 8'hE0);
      check("mr_port", out_port, 4'd0);
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
